// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: operation classes, the in-flight
// tracker entry, and the class-to-latency helper.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    CLASS_ALU  = 2'b00,
    CLASS_LOAD = 2'b01,
    CLASS_MUL  = 2'b10,
    CLASS_RSVD = 2'b11
  } op_class_e;

  // Tracker fields are sized for the widest supported configuration so the
  // entry type can live here, outside any parameterised module.
  localparam int TRK_RD_W   = 8;
  localparam int LAT_W      = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [TRK_RD_W-1:0] rd;
    logic [LAT_W-1:0]    lat;
  } trk_entry_t;

  // The reserved class encoding behaves exactly like ALU.
  function automatic logic [LAT_W-1:0] class_lat(op_class_e cls, int alu_lat,
                                                 int load_lat, int mul_lat);
    case (cls)
      CLASS_LOAD: return LAT_W'(load_lat);
      CLASS_MUL:  return LAT_W'(mul_lat);
      default:    return LAT_W'(alu_lat);
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side interface of the hazard scoreboard: ID instruction fields in,
// stall / issue / forwarding selects out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_rs_used;
  logic                  id_rt_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic [1:0]            id_class;
  logic                  flush;

  logic                  stall;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  issue;
  logic [SEL_W-1:0]      ex_fwd_rs_sel;
  logic [SEL_W-1:0]      ex_fwd_rt_sel;
  logic [31:0]           stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_reg_write, id_class, flush,
    input  stall, pc_write, if_id_write, issue, ex_fwd_rs_sel,
           ex_fwd_rt_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_reg_write, id_class, flush,
    output stall, pc_write, if_id_write, issue, ex_fwd_rs_sel,
           ex_fwd_rt_sel, stall_count
  );
endinterface

// File: rtl/hazard_match.sv
// Youngest-match priority search of one source operand over the in-flight
// tracker; reports the forwarding select and whether the producer is not ready.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int SEL_W      = 2,
  parameter int REG_ADDR_W = 5
) (
  input  trk_entry_t [STAGES-1:0] trk_i,
  input  logic [REG_ADDR_W-1:0]   src_i,
  input  logic                    used_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    hazard_o
);

  // The oldest entry is skipped: it is writing the register file this cycle,
  // and the write-through file already returns its value to decode.
  // Scanning oldest-first lets the youngest match overwrite older ones.
  always_comb begin
    // NOTE: every output gets a default before any condition so no latch is inferred.
    sel_o    = SEL_W'(FWD_SEL_RF);
    hazard_o = 1'b0;
    if (used_i && (src_i != '0)) begin
      for (int i = STAGES - 2; i >= 0; i--) begin
        if (trk_i[i].valid && (trk_i[i].rd == TRK_RD_W'(src_i))) begin
          sel_o    = SEL_W'(i + 1);
          hazard_o = LAT_W'(i + 1) < trk_i[i].lat;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised load-use / multi-latency hazard scoreboard with EX forwarding
// selects. HAZARD_STALL_COUNT_EN adds a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int ALU_LAT    = 1,
  parameter int LOAD_LAT   = 2,
  parameter int MUL_LAT    = 2,
  parameter int SEL_W      = $clog2(STAGES)
) (
  input logic          clk,
  input logic          reset,
  hazard_scoreboard_if.slave bus
);

  trk_entry_t [STAGES-1:0] trk_q;
  trk_entry_t [STAGES-1:0] trk_d;

  logic [SEL_W-1:0] rs_sel;
  logic [SEL_W-1:0] rt_sel;
  logic [SEL_W-1:0] rs_sel_q;
  logic [SEL_W-1:0] rt_sel_q;
  logic             rs_hazard;
  logic             rt_hazard;
  logic             stall;
  logic             issue;

  hazard_match #(
    .STAGES     (STAGES),
    .SEL_W      (SEL_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rs_match (
    .trk_i    (trk_q),
    .src_i    (bus.id_rs),
    .used_i   (bus.id_rs_used),
    .sel_o    (rs_sel),
    .hazard_o (rs_hazard)
  );

  hazard_match #(
    .STAGES     (STAGES),
    .SEL_W      (SEL_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rt_match (
    .trk_i    (trk_q),
    .src_i    (bus.id_rt),
    .used_i   (bus.id_rt_used),
    .sel_o    (rt_sel),
    .hazard_o (rt_hazard)
  );

  // Flush and reset both win over a hazard: the ID slot becomes a bubble.
  always_comb begin
    stall = bus.id_valid && !bus.flush && !reset && (rs_hazard || rt_hazard);
    issue = bus.id_valid && !bus.flush && !reset && !stall;
  end

  always_comb begin
    trk_d = '0;
    if (issue) begin
      trk_d[0].valid = bus.id_reg_write && (bus.id_rd != '0);
      trk_d[0].rd    = TRK_RD_W'(bus.id_rd);
      trk_d[0].lat   = class_lat(op_class_e'(bus.id_class), ALU_LAT, LOAD_LAT, MUL_LAT);
    end
    for (int j = 1; j < STAGES; j++) begin
      trk_d[j] = trk_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the tracker is a handful of flops, so the whole entry is cleared,
    // not just the valid bits, keeping rd/lat free of X after reset.
    if (reset) begin
      trk_q    <= '0;
      rs_sel_q <= SEL_W'(FWD_SEL_RF);
      rt_sel_q <= SEL_W'(FWD_SEL_RF);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      trk_q    <= trk_d;
      rs_sel_q <= issue ? rs_sel : SEL_W'(FWD_SEL_RF);
      rt_sel_q <= issue ? rt_sel : SEL_W'(FWD_SEL_RF);
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.stall         = stall;
  assign bus.pc_write      = ~stall;
  assign bus.if_id_write   = ~stall;
  assign bus.issue         = issue;
  assign bus.ex_fwd_rs_sel = rs_sel_q;
  assign bus.ex_fwd_rt_sel = rt_sel_q;

endmodule
